// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path constants and the queue entry layout.
// Used by instr_fetch_unit and fetch_queue.
package instr_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0]    RESET_VECTOR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0013;

  // One queued fetch: the byte PC and the instruction word read at that PC.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetched {pc, instr} entries.
// Head is read combinationally so a pushed entry is visible the next cycle.
// Flush has priority over push; pop is ignored when empty; pointers wrap
// naturally because DEPTH is a power of two.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // A full queue may still accept a push when the head leaves this cycle.
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  // Entry storage: written on push, never reset (contents gated by count).
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the word address to the
// instruction memory, captures the returned word into fetch_queue and hands
// {pc, instr} pairs to decode over valid/ready. A redirect flushes the queue
// and reloads the PC; it wins over everything else.
// Optional feature macro: FETCH_MISALIGN_EN adds a sticky misaligned-redirect
// error output (o_misalign_err) that halts fetch until an aligned redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_en,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_dword,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_instr,
  output logic [31:0]       o_out_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              o_misalign_err
`endif
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_redirect_target;
  logic            w_halt;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign o_imem_addr = r_pc[PC_W-1 -: ADDR_W];

`ifdef FETCH_MISALIGN_EN
  logic r_misalign;

  assign w_redirect_target = i_redirect_pc;
  assign w_halt            = r_misalign;
  assign o_misalign_err    = r_misalign;

  // Sticky error: every redirect re-evaluates it, so an aligned one clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (i_redirect_valid) begin
      r_misalign <= |i_redirect_pc[1:0];
    end
  end
`else
  logic w_unused_low_bits;

  // Low byte-offset bits of the target carry no meaning without the error path.
  assign w_unused_low_bits = ^i_redirect_pc[1:0];
  assign w_redirect_target = align_pc(i_redirect_pc);
  assign w_halt            = 1'b0;
`endif

  assign o_out_valid = ~w_empty & ~w_halt;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_push      = i_fetch_en & ~i_redirect_valid & ~w_halt & (~w_full | w_pop);

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = i_imem_dword;

  assign o_out_pc    = w_head.pc;
  assign o_out_instr = w_head.instr;

  // PC: redirect reloads, a successful push advances by one word (wraps at 2^32).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_push) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_din   (w_push_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule
